// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_flex #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         wr_en,
   input  logic [WIDTH-1:0]             wr_data,
   output logic                         full,
   output logic                         almost_full,
   input  logic                         rd_en,
   output logic [WIDTH-1:0]             rd_data,
   output logic                         empty,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         underflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
   localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          wa, ra;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign full         = (count_q == CNT_FULL);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CNT_AF);
   assign almost_empty = (count_q <= CNT_AE);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign wa = wr_en & ~full;
   assign ra = rd_en & ~empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (wr_en & full);
      underflow_d = underflow_q | (rd_en & empty);
      if (clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wa) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (ra) rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({wa, ra})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wa && !clr) mem[wr_ptr_q] <= wr_data;
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rd_data = mem[rd_ptr_q];
`else
   logic [WIDTH-1:0] rd_data_q, rd_data_d;

   always_comb begin
      rd_data_d = rd_data_q;
      if (ra && !clr) rd_data_d = mem[rd_ptr_q];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data_q <= '0;
      else     rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;
`endif

endmodule
